// File: rtl/fir_ctrl_pkg.sv
// Shared FIR control definitions: state codes and default filter geometry.
// Latency: n/a (constants only).
// Backpressure: n/a.
package fir_ctrl_pkg;

  // Default filter geometry, shared with the receive controller and datapath
  localparam int FIR_TAPS   = 8;
  localparam int FIR_ADDR_W = 3;

  // Sequencer state codes
  localparam logic [3:0] IDLE   = 4'd0;
  localparam logic [3:0] SHIFT  = 4'd1;
  localparam logic [3:0] CLR    = 4'd2;
  localparam logic [3:0] MAC    = 4'd3;
  localparam logic [3:0] LATCH  = 4'd4;
  localparam logic [3:0] TX_MSB = 4'd5;
  localparam logic [3:0] GAP    = 4'd6;
  localparam logic [3:0] TX_LSB = 4'd7;
  localparam logic [3:0] DONE   = 4'd8;

endpackage

// File: rtl/fir_seq_cu_if.sv
// Control bundle between the FIR sequencer, the RX/TX UART paths and the MAC datapath.
// Latency: n/a (wires only).
// Backpressure: TxD_busy holds the sequencer in its transmit states.
interface fir_seq_cu_if
  import fir_ctrl_pkg::*;
#(
  parameter int ADDR_W = FIR_ADDR_W
) ();

  logic              FIR_strt;
  logic              TxD_busy;
  logic              shift_en;
  logic              acc_clr;
  logic              mac_en;
  logic [ADDR_W-1:0] tap_addr;
  logic              out_load;
  logic              tx_sel;
  logic              tx_start;
  logic              fir_busy;
  logic              fir_done;
  logic              strt_drop;

  // Sequencer side: consumes start/busy, drives all control strobes
  modport master (
    input  FIR_strt, TxD_busy,
    output shift_en, acc_clr, mac_en, tap_addr, out_load,
           tx_sel, tx_start, fir_busy, fir_done, strt_drop
  );

  // Datapath / UART side: the mirror image
  modport slave (
    output FIR_strt, TxD_busy,
    input  shift_en, acc_clr, mac_en, tap_addr, out_load,
           tx_sel, tx_start, fir_busy, fir_done, strt_drop
  );

endinterface

// File: rtl/fir_seq_cu_tap_cnt.sv
// Tap index counter for the MAC phase with clear, enable and terminal-count flag.
// Latency: count updates one cycle after enable; tc_o is combinational on the count.
// Backpressure: none; the sequencer decides when to count.
module fir_tap_cnt
  import fir_ctrl_pkg::*;
#(
  parameter int TAPS   = FIR_TAPS,
  parameter int ADDR_W = FIR_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              en_i,
  output logic [ADDR_W-1:0] cnt_o,
  output logic              tc_o
);

  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] cnt_d;

  // Clear has priority over counting so the last MAC cycle can wrap to zero
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + ADDR_W'(1);
    end
  end

  // Count register, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == ADDR_W'(TAPS - 1));

endmodule

// File: rtl/fir_seq_cu.sv
// FIR control unit: shift sample, run TAPS MAC cycles, latch, send MSB then LSB byte.
// Latency: shift_en one cycle after FIR_strt; MSB tx_start TAPS+4 cycles after it.
// Backpressure: TxD_busy stalls TX_MSB/TX_LSB; FIR_SEQ_PEND_EN queues one start while busy.
module fir_seq_cu
  import fir_ctrl_pkg::*;
#(
  parameter int TAPS   = FIR_TAPS,
  parameter int ADDR_W = FIR_ADDR_W
) (
  input logic          clk,
  input logic          rst,
  fir_seq_cu_if.master ctl
);

  logic [3:0]        state_q;
  logic [3:0]        state_d;
  logic              drop_q;
  logic              drop_d;
`ifdef FIR_SEQ_PEND_EN
  logic              pend_q;
  logic              pend_d;
`endif

  logic [ADDR_W-1:0] cnt;
  logic              cnt_tc;
  logic              cnt_clr;
  logic              cnt_en;
  logic              strt_busy;

  assign cnt_en    = (state_q == MAC);
  assign cnt_clr   = (state_q == CLR) || ((state_q == MAC) && cnt_tc);
  // A start seen in DONE is resolved by the DONE transition itself
  assign strt_busy = ctl.FIR_strt && (state_q != IDLE) && (state_q != DONE);

  fir_tap_cnt #(
    .TAPS   (TAPS),
    .ADDR_W (ADDR_W)
  ) u_tap_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .cnt_o (cnt),
    .tc_o  (cnt_tc)
  );

  // State, drop pulse and pending-start registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      drop_q  <= 1'b0;
`ifdef FIR_SEQ_PEND_EN
      pend_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
`ifdef FIR_SEQ_PEND_EN
      pend_q  <= pend_d;
`endif
    end
  end

  // Next-state, drop and pending-flag decisions
  always_comb begin
    state_d = state_q;
    drop_d  = 1'b0;
`ifdef FIR_SEQ_PEND_EN
    pend_d  = pend_q;
    if (strt_busy) begin
      if (pend_q) drop_d = 1'b1;
      else        pend_d = 1'b1;
    end
`else
    if (strt_busy) drop_d = 1'b1;
`endif
    case (state_q)
      IDLE:    if (ctl.FIR_strt) state_d = SHIFT;
      SHIFT:   state_d = CLR;
      CLR:     state_d = MAC;
      MAC:     if (cnt_tc) state_d = LATCH;
      LATCH:   state_d = TX_MSB;
      TX_MSB:  if (!ctl.TxD_busy) state_d = GAP;
      GAP:     state_d = TX_LSB;
      TX_LSB:  if (!ctl.TxD_busy) state_d = DONE;
      DONE: begin
`ifdef FIR_SEQ_PEND_EN
        // Queued start runs next; a fresh start here overflows the 1-deep queue
        if (pend_q) begin
          state_d = SHIFT;
          pend_d  = 1'b0;
          drop_d  = ctl.FIR_strt;
        end else if (ctl.FIR_strt) begin
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
`else
        state_d = IDLE;
        drop_d  = ctl.FIR_strt;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Moore control decode; reset forces every strobe low in the same cycle
  always_comb begin
    ctl.shift_en  = 1'b0;
    ctl.acc_clr   = 1'b0;
    ctl.mac_en    = 1'b0;
    ctl.tap_addr  = '0;
    ctl.out_load  = 1'b0;
    ctl.tx_sel    = 1'b0;
    ctl.tx_start  = 1'b0;
    ctl.fir_busy  = 1'b0;
    ctl.fir_done  = 1'b0;
    ctl.strt_drop = 1'b0;
    if (!rst) begin
      ctl.fir_busy  = (state_q != IDLE);
      ctl.strt_drop = drop_q;
      case (state_q)
        SHIFT:  ctl.shift_en = 1'b1;
        CLR:    ctl.acc_clr  = 1'b1;
        MAC: begin
          ctl.mac_en   = 1'b1;
          ctl.tap_addr = cnt;
        end
        LATCH:  ctl.out_load = 1'b1;
        TX_MSB: begin
          ctl.tx_sel   = 1'b1;
          ctl.tx_start = !ctl.TxD_busy;
        end
        GAP:    ctl.tx_sel   = 1'b1;
        TX_LSB: ctl.tx_start = !ctl.TxD_busy;
        DONE:   ctl.fir_done = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/fir_seq_cu.md
Name: fir_seq_cu

Overview:
Control unit that sequences the FIR datapath for each 16-bit input sample assembled by the UART receive path.
- On a one-cycle FIR_strt pulse it shifts the sample into the delay line and runs the multiply-accumulate over all taps.
- It then latches the result and hands the result's MSB and LSB bytes to the UART transmitter, in that order.
- It sits between the receive controller (source of FIR_strt) and the FIR/MAC datapath plus TX serializer. It generates control only and carries no data.

Parameters:
- TAPS, 8, number of filter taps (≥2). One MAC cycle per tap.
- ADDR_W, 3, width of tap_addr; must satisfy 2**ADDR_W ≥ TAPS.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  synchronous, active-high reset.
- FIR_strt  in  1  one-cycle pulse: a new sample is held valid in the input register.
- TxD_busy  in  1  UART transmitter busy. Contract: rises no later than the cycle after tx_start.
- shift_en  out  1  push the input sample into the delay line.
- acc_clr  out  1  clear the accumulator.
- mac_en  out  1  accumulate tap[tap_addr] × coef[tap_addr].
- tap_addr  out  ADDR_W  tap/coefficient index during MAC.
- out_load  out  1  load the accumulator (rounded to 16 bits) into the output register.
- tx_sel  out  1  1 = drive MSB byte to the transmitter, 0 = drive LSB byte.
- tx_start  out  1  one-cycle byte send request.
- fir_busy  out  1  high in every state except IDLE.
- fir_done  out  1  one-cycle pulse after the LSB has been accepted.
- strt_drop  out  1  one-cycle pulse when a FIR_strt is discarded.

Behaviour:
- The state register and tap counter reset synchronously to IDLE / 0.
- All outputs are Moore-decoded from the state plus the counter. Exceptions: tx_start is qualified by ~TxD_busy, and strt_drop is a registered pulse.
- In reset, every output is 0. A reset asserted mid-operation returns to IDLE next edge: no further strobes, and a pending start is cleared.
- States and transitions:
  - IDLE: FIR_strt → SHIFT, else stay.
  - SHIFT: shift_en=1 → CLR.
  - CLR: acc_clr=1, counter←0 → MAC.
  - MAC: mac_en=1, tap_addr=counter. Counter increments each cycle. When counter==TAPS-1 → LATCH (counter←0). This is exactly TAPS cycles, with addresses 0..TAPS-1 ascending.
  - LATCH: out_load=1 → TX_MSB.
  - TX_MSB: tx_sel=1, tx_start=~TxD_busy. If ~TxD_busy → GAP, else stay.
  - GAP: tx_sel=1, tx_start=0, one cycle (lets busy rise) → TX_LSB.
  - TX_LSB: tx_sel=0, tx_start=~TxD_busy. If ~TxD_busy → DONE, else stay.
  - DONE: fir_done=1 → IDLE.
- Latency: with FIR_strt sampled at edge k and the transmitter idle:
  - shift_en is high in cycle k+1.
  - The MSB tx_start is in cycle k+TAPS+4 (k+12 for TAPS=8).
  - The LSB waits for TxD_busy to fall.
- tx_start is never high on two consecutive cycles.
- tx_sel holds from TX_MSB through GAP, so the MSB byte stays stable while the transmitter captures it.
- FIR_strt in IDLE is accepted. FIR_strt in any other state is handled per the optional feature.
- FIR_strt coincident with rst is ignored.

Optional Feature:
- Macro FIR_SEQ_PEND_EN.
- Defined: a 1-deep pending flag.
  - FIR_strt while busy sets the flag.
  - DONE with the flag set goes directly to SHIFT and clears the flag; fir_busy stays high.
  - A second FIR_strt while the flag is already set → strt_drop pulse; the flag stays set.
- Undefined: every FIR_strt outside IDLE → strt_drop pulse one cycle later, and the sample is ignored.

Decomposition:
- Shared package fir_ctrl_pkg: state encoding localparams (IDLE, SHIFT, CLR, MAC, LATCH, TX_MSB, GAP, TX_LSB, DONE as 4-bit codes) and default TAPS/ADDR_W. The receive controller and the datapath read TAPS from the same package.
- One natural sub-module: fir_tap_cnt, an ADDR_W-bit counter with clear/enable and a terminal-count flag (==TAPS-1).

Test Plan:
- Reset: hold rst 3 cycles, toggling FIR_strt → all outputs 0, state IDLE; after release, fir_busy=0.
- Single sample, TAPS=8, TxD_busy=0, FIR_strt at k → shift_en at k+1, acc_clr at k+2, mac_en k+3..k+10 with tap_addr 0..7, out_load k+11, tx_start (tx_sel=1) k+12.
  - Then model busy high for 10 cycles → LSB tx_start (tx_sel=0) on the first busy-low cycle in TX_LSB, fir_done the next cycle.
- TxD_busy already high at LATCH for 5 cycles → tx_start stays 0 and tx_sel=1 throughout; tx_start pulses once on the first busy-low cycle.
- FIR_strt at MAC cycle 3:
  - Without FIR_SEQ_PEND_EN → strt_drop one cycle later, return to IDLE after DONE.
  - With it → SHIFT immediately after DONE; two starts during busy → exactly one strt_drop.
- Reset asserted in TX_MSB → next cycle IDLE, tx_start=0; a following FIR_strt runs a full clean sequence.
- Back-to-back FIR_strt in the cycle after DONE → accepted; tap_addr restarts at 0.
